// File: rtl/peribus_arbiter.sv
// peribus_arbiter: two-master round-robin arbiter and strobe sequencer
// in front of the peripheral bus controller.
//
// Ports:
//   CLOCK_50, reset         clock, synchronous active-high reset
//   m{0,1}_req/_we/_addr    master request, direction, address
//   m{0,1}_wdata            master write data
//   m{0,1}_rdata, _ack      registered read data, one-cycle ack
//   pb_addr, pb_write_data  bus address / write data (held per txn)
//   pb_read_data            bus read data
//   pb_write_enable         bus write strobe
//   pb_read_enable          bus read strobe
//   busy, owner             transaction in flight, granted master
module peribus_arbiter #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic [ADDR_WIDTH-1:0] pb_addr,
    output logic [DATA_WIDTH-1:0] pb_write_data,
    input  logic [DATA_WIDTH-1:0] pb_read_data,
    output logic                  pb_write_enable,
    output logic                  pb_read_enable,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pb_we_q, pb_we_d;
    logic                  pb_re_q, pb_re_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  grant;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        busy_d       = busy_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        pb_we_d      = 1'b0;
        pb_re_d      = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        grant        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that did not go last wins.
                    grant   = (m0_req && m1_req) ? ~last_owner_q : m1_req;
                    owner_d = grant;
                    we_d    = grant ? m1_we    : m0_we;
                    addr_d  = grant ? m1_addr  : m0_addr;
                    wdata_d = grant ? m1_wdata : m0_wdata;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'd0;
                pb_we_d = we_q;
                pb_re_d = ~we_q;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == LAST_CNT) begin
                    // Capture on the edge that ends the last strobe cycle.
                    if (!we_q && !owner_q) rdata0_d = pb_read_data;
                    if (!we_q &&  owner_q) rdata1_d = pb_read_data;
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    pb_we_d = we_q;
                    pb_re_d = ~we_q;
                end
            end
            HOLD: begin
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                state_d = ACK;
            end
            ACK: begin
                last_owner_d = owner_q;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pb_we_q      <= 1'b0;
            pb_re_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pb_we_q      <= pb_we_d;
            pb_re_q      <= pb_re_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign pb_addr         = addr_q;
    assign pb_write_data   = wdata_q;
    assign pb_write_enable = pb_we_q;
    assign pb_read_enable  = pb_re_q;
    assign m0_ack          = ack0_q;
    assign m1_ack          = ack1_q;
    assign m0_rdata        = rdata0_q;
    assign m1_rdata        = rdata1_q;
    assign busy            = busy_q;
    assign owner           = owner_q;

endmodule

// File: tb/tb_peribus_arbiter.sv
// tb_peribus_arbiter: directed vector bench for peribus_arbiter.
// Table of transactions plus reset and early-drop sequences.
module tb_peribus_arbiter;

    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr, pb_addr;
    logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [15:0] pb_write_data, pb_read_data;
    logic        m0_ack, m1_ack, pb_write_enable, pb_read_enable;
    logic        busy, owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    peribus_arbiter dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_rdata       (m0_rdata),
        .m0_ack         (m0_ack),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_rdata       (m1_rdata),
        .m1_ack         (m1_ack),
        .pb_addr        (pb_addr),
        .pb_write_data  (pb_write_data),
        .pb_read_data   (pb_read_data),
        .pb_write_enable(pb_write_enable),
        .pb_read_enable (pb_read_enable),
        .busy           (busy),
        .owner          (owner)
    );

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic [15:0] prd;
        logic        own;
        logic        ewe;
        logic [7:0]  eaddr;
        logic [15:0] ewd;
        logic [15:0] er0, er1;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state",
              {busy, owner, pb_write_enable, pb_read_enable, m0_ack, m1_ack,
               pb_addr, pb_write_data, m0_rdata, m1_rdata},
              64'h0);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        logic eb, ewe_s, ere_s, ea0, ea1;
        v = vt[n];
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        pb_read_data = v.prd;
        @(posedge clk);
        for (int k = 1; k <= 4 + SC; k++) begin
            #1;
            eb    = (k <= 3 + SC);
            ewe_s = (k >= 2) && (k <= 1 + SC) && v.ewe;
            ere_s = (k >= 2) && (k <= 1 + SC) && !v.ewe;
            ea0   = (k == 3 + SC) && !v.own;
            ea1   = (k == 3 + SC) && v.own;
            check($sformatf("vec%0d_cyc%0d", n, k),
                  {busy, eb ? owner : 1'b0, pb_write_enable, pb_read_enable,
                   m0_ack, m1_ack, pb_addr, pb_write_data},
                  {eb, eb ? v.own : 1'b0, ewe_s, ere_s, ea0, ea1,
                   v.eaddr, v.ewd});
            if (k == 3 + SC)
                check($sformatf("vec%0d_rdata", n), {m0_rdata, m1_rdata},
                      {v.er0, v.er1});
            if (k < 4 + SC) @(posedge clk);
        end
    endtask

    initial begin
        int   acks0, acks1, busys;
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        pb_read_data = 0;

        //        rst r0 w0 a0     d0        r1 w1 a1     d1        prd       own we addr  wd        er0       er1
        vt[0] = '{0, 1, 0, 8'h00, 16'h7777, 0, 0, 8'h00, 16'h0000, 16'h1234, 0, 0, 8'h00, 16'h7777, 16'h1234, 16'h0000};
        vt[1] = '{0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h05, 16'hAA55, 16'hDEAD, 1, 1, 8'h05, 16'hAA55, 16'h1234, 16'h0000};
        vt[2] = '{0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h04, 16'h00F0, 16'h0101, 1, 1, 8'h04, 16'h00F0, 16'h1234, 16'h0000};
        vt[3] = '{1, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h3333, 16'hBEEF, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 16'h0000};
        vt[4] = '{0, 0, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h3333, 16'h5A5A, 1, 0, 8'h20, 16'h3333, 16'hBEEF, 16'h5A5A};
        vt[5] = '{0, 1, 1, 8'h30, 16'h1111, 1, 0, 8'h31, 16'h4444, 16'h0A0A, 0, 1, 8'h30, 16'h1111, 16'hBEEF, 16'h5A5A};
        vt[6] = '{0, 1, 1, 8'h30, 16'h1111, 1, 0, 8'h31, 16'h4444, 16'h0B0B, 1, 0, 8'h31, 16'h4444, 16'hBEEF, 16'h0B0B};
        vt[7] = '{0, 1, 1, 8'h32, 16'h2222, 1, 0, 8'h31, 16'h4444, 16'h0C0C, 0, 1, 8'h32, 16'h2222, 16'hBEEF, 16'h0B0B};
        vt[8] = '{0, 1, 1, 8'h32, 16'h2222, 1, 0, 8'h31, 16'h4444, 16'h0D0D, 1, 0, 8'h31, 16'h4444, 16'hBEEF, 16'h0D0D};

        @(negedge clk);
        do_reset();
        for (int n = 0; n < 9; n++) begin
            if (vt[n].rst) do_reset();
            run_vec(n);
        end
        m0_req = 0;
        m1_req = 0;

        // Reset during the second strobe cycle of a read.
        @(posedge clk);
        #1;
        m0_req = 1; m0_we = 0; m0_addr = 8'h40; pb_read_data = 16'h9999;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_strobe_pre", {pb_read_enable, busy}, 2'b11);
        reset  = 1'b1;
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_strobe_post",
              {busy, pb_write_enable, pb_read_enable, m0_ack, m1_ack,
               m0_rdata, m1_rdata},
              64'h0);
        reset = 1'b0;
        acks0 = 0; acks1 = 0; busys = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            acks0 += int'(m0_ack);
            acks1 += int'(m1_ack);
            busys += int'(busy);
        end
        check("rst_strobe_noack", {32'(acks0 + acks1), 32'(busys)}, 64'h0);

        // m0 drops req during SETUP: transaction completes once.
        m0_req = 1; m0_we = 0; m0_addr = 8'h50; pb_read_data = 16'h6789;
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        acks0 = 0; acks1 = 0; busys = 0;
        for (int i = 0; i < 12; i++) begin
            acks0 += int'(m0_ack);
            acks1 += int'(m1_ack);
            busys += int'(busy);
            @(posedge clk);
            #1;
        end
        check("drop_ack0", 64'(acks0), 64'd1);
        check("drop_ack1", 64'(acks1), 64'd0);
        check("drop_busy", 64'(busys), 64'(3 + SC));
        check("drop_rdata", {48'h0, m0_rdata}, 64'h6789);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
